// File: rtl/s8_word_engine_if.sv
// ----------------------------------------------------------------------------
// s8_word_engine_if
//   Handshake bundle for s8_word_engine.
//   Input side : in_valid / in_ready / in_data  (word; byte i = in_data[8i+7:8i])
//   Output side: out_valid / out_ready / out_data (substituted word)
//   modport master : producer/consumer that talks to the engine
//   modport slave  : the engine itself
// ----------------------------------------------------------------------------
interface s8_word_engine_if #(
    parameter int WORD_BYTES = 16
);
    logic                      in_valid;
    logic                      in_ready;
    logic [8*WORD_BYTES-1:0]   in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [8*WORD_BYTES-1:0]   out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/s8_word_engine.sv
// ----------------------------------------------------------------------------
// s8_word_engine
//   Multi-cycle Enocoro-128v2 S8 substitution engine. A WORD_BYTES-byte word
//   is accepted, substituted LANES bytes per cycle (lowest bytes first) and
//   returned over a second valid/ready handshake.
//
// Parameters
//   WORD_BYTES : bytes per word (multiple of LANES)
//   LANES      : parallel S8 lanes, 1..WORD_BYTES
//
// Ports
//   clk  : system clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : s8_word_engine_if.slave (in_valid/in_ready/in_data,
//          out_valid/out_ready/out_data)
//   busy : high while processing chunks
//
// Build option
//   S8_LANE_PIPE_EN : adds a register stage between lane outputs and the
//                     work-register write-back (latency N+2 instead of N+1).
// ----------------------------------------------------------------------------
module s8_word_engine #(
    parameter int WORD_BYTES = 16,
    parameter int LANES      = 4
) (
    input  logic                clk,
    input  logic                rst,
    s8_word_engine_if.slave     bus,
    output logic                busy
);

    localparam int unsigned N  = WORD_BYTES / LANES;
    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned LW = 8 * LANES;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if ((LANES < 1) || (WORD_BYTES % LANES != 0)) begin : g_param_check
        $error("s8_word_engine: WORD_BYTES must be a multiple of LANES and LANES >= 1");
    end

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [8*WORD_BYTES-1:0] work;
    logic                    idle_q;
    logic                    out_valid_q;
    logic                    busy_q;

    logic [LW-1:0]           lane_in;
    logic [LW-1:0]           lane_out;
    logic [31:0]             base;

    function automatic logic [3:0] s4(input logic [3:0] x);
        case (x)
            4'h0: return 4'h1;
            4'h1: return 4'h3;
            4'h2: return 4'h9;
            4'h3: return 4'hA;
            4'h4: return 4'h5;
            4'h5: return 4'hE;
            4'h6: return 4'h7;
            4'h7: return 4'h2;
            4'h8: return 4'hD;
            4'h9: return 4'h0;
            4'hA: return 4'hC;
            4'hB: return 4'hF;
            4'hC: return 4'h4;
            4'hD: return 4'h8;
            4'hE: return 4'h6;
            default: return 4'hB;
        endcase
    endfunction

    // Multiply by x in GF(2^4), x^4 = x + 1.
    function automatic logic [3:0] xtime(input logic [3:0] v);
        return {v[2:0], 1'b0} ^ {2'b00, v[3], v[3]};
    endfunction

    // 0xE = x^3 + x^2 + x
    function automatic logic [3:0] mul_e(input logic [3:0] v);
        logic [3:0] t1, t2, t3;
        t1 = xtime(v);
        t2 = xtime(t1);
        t3 = xtime(t2);
        return t1 ^ t2 ^ t3;
    endfunction

    function automatic logic [7:0] s8(input logic [7:0] x);
        logic [3:0] a, b, h, l;
        a = s4(x[7:4]);
        b = s4(x[3:0]);
        h = s4(a ^ mul_e(b) ^ 4'hA);
        l = s4(b ^ mul_e(a) ^ 4'h5);
        return {h[2:0], l, h[3]};
    endfunction

    // Clamp keeps the select in range once the pipelined build's issue
    // counter has run one past the last chunk.
    always_comb begin
        base = '0;
        if (32'(cnt) < N)
            base = 32'(cnt) * LW;
        lane_in = work[base +: LW];
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_out[8*g +: 8] = s8(lane_in[8*g +: 8]);
    end

`ifdef S8_LANE_PIPE_EN
    logic [LW-1:0] pipe_data;
    logic [CW-1:0] pipe_idx;
    logic          pipe_valid;
    logic [31:0]   pipe_base;

    always_comb pipe_base = 32'(pipe_idx) * LW;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            work        <= '0;
            idle_q      <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef S8_LANE_PIPE_EN
            pipe_data   <= '0;
            pipe_idx    <= '0;
            pipe_valid  <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        work   <= bus.in_data;
                        cnt    <= '0;
                        state  <= S_BUSY;
                        idle_q <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                S_BUSY: begin
`ifdef S8_LANE_PIPE_EN
                    // Issue side runs cnt 0..N-1; write-back side trails by
                    // one cycle and decides completion.
                    if (32'(cnt) < N) begin
                        pipe_data  <= lane_out;
                        pipe_idx   <= cnt;
                        pipe_valid <= 1'b1;
                        cnt        <= cnt + 1'b1;
                    end else begin
                        pipe_valid <= 1'b0;
                    end
                    if (pipe_valid) begin
                        work[pipe_base +: LW] <= pipe_data;
                        if (pipe_idx == LAST) begin
                            state       <= S_DONE;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
`else
                    work[base +: LW] <= lane_out;
                    cnt              <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state       <= S_DONE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                    end
`endif
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        if (bus.in_valid) begin
                            work   <= bus.in_data;
                            cnt    <= '0;
                            state  <= S_BUSY;
                            busy_q <= 1'b1;
                        end else begin
                            state  <= S_IDLE;
                            idle_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    idle_q <= 1'b1;
                end
            endcase
        end
    end

    // Ready also opens in S_DONE when the consumer drains the result, so a
    // new word can follow without an idle bubble.
    assign bus.in_ready  = idle_q | (out_valid_q & bus.out_ready);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = work;
    assign busy          = busy_q;

endmodule
